// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared constants, grant encoding and address helpers for the memory port arbiter
package mem_port_arbiter_pkg;

    // Byte offset inside a word; word index starts right above it
    localparam int OFS_W = 2;

    // Width of the I-side starvation counter, saturating at its all-ones value
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_I,
        GNT_D
    } gnt_e;

    // A word access is misaligned when any byte-offset bit is set
    function automatic logic misaligned(input logic [31:0] addr);
        return |addr[OFS_W-1:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_resp.sv
// mem_resp_reg: one-cycle registered response stage (rvalid/err/rdata) for one requester
module mem_resp_reg
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_i,
    input  logic             err_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             rvalid_o,
    output logic             err_o,
    output logic [WIDTH-1:0] rdata_o
);

    logic             rvalid_q, rvalid_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Capture strobe produces a single-cycle pulse; data is held between responses
    always_comb begin
        rvalid_d = cap_i;
        err_d    = cap_i & err_i;
        rdata_d  = cap_i ? data_i : rdata_q;
    end

    // Response registers; asynchronous active-low reset drops any pending response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word memory between fetch (I) and load/store (D) requesters
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int WORD         = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic             i_ack,
    output logic             i_rvalid,
    output logic [WIDTH-1:0] i_rdata,
    output logic             i_err,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [31:0]      d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_ack,
    output logic             d_rvalid,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_err,
    output logic [31:0]      m_addr,
    output logic [WIDTH-1:0] m_in,
    output logic             m_we,
    input  logic [WIDTH-1:0] m_out
);

    localparam int AW = $clog2(WORD);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    gnt_e             gnt;
    logic             i_mis, d_mis;
    logic [31:0]      sel_addr;
    logic             unused_addr;

    assign i_mis = misaligned(i_addr);
    assign d_mis = misaligned(d_addr);

    // Fixed D priority unless I has been denied STARVE_LIMIT times; nothing is granted in reset
    always_comb begin
        gnt = !rst ? GNT_NONE :
              (d_req && !(i_req && starve_cnt_q >= LIMIT)) ? GNT_D :
              i_req ? GNT_I : GNT_NONE;
    end

    assign i_ack = (gnt == GNT_I);
    assign d_ack = (gnt == GNT_D);

    // Memory drive: address follows I when D is not granted; misaligned stores never write
    always_comb begin
        sel_addr = d_ack ? d_addr : i_addr;
        m_addr   = {{(32-AW){1'b0}}, sel_addr[OFS_W +: AW]};
        m_in     = d_wdata;
        m_we     = d_ack & d_we & ~d_mis;
    end

    // Upper address bits beyond the word index are intentionally ignored (wrap modulo WORD)
    assign unused_addr = ^{sel_addr[31:OFS_W+AW], sel_addr[OFS_W-1:0]};

    // Count consecutive denied fetch cycles, saturating; an I grant clears it
    always_comb begin
        starve_cnt_d = i_ack ? '0 :
                       (i_req && starve_cnt_q != CNT_MAX) ? starve_cnt_q + 1'b1 :
                       starve_cnt_q;
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_cnt_q <= '0;
        else      starve_cnt_q <= starve_cnt_d;
    end

    mem_resp_reg #(.WIDTH(WIDTH)) u_i_resp (
        .clk      (clk),
        .rst      (rst),
        .cap_i    (i_ack),
        .err_i    (i_mis),
        .data_i   (i_mis ? '0 : m_out),
        .rvalid_o (i_rvalid),
        .err_o    (i_err),
        .rdata_o  (i_rdata)
    );

    mem_resp_reg #(.WIDTH(WIDTH)) u_d_resp (
        .clk      (clk),
        .rst      (rst),
        .cap_i    (d_ack),
        .err_i    (d_mis),
        .data_i   (d_mis ? '0 : m_out),
        .rvalid_o (d_rvalid),
        .err_o    (d_err),
        .rdata_o  (d_rdata)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a behavioural memory
module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        i_req, i_ack, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ack, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] m_addr, m_in, m_out;
    logic        m_we;
    logic [31:0] mem [0:1023];
    int          n_tests, n_fail;

    mem_port_arbiter #(.WIDTH(32), .WORD(1024), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_addr(m_addr), .m_in(m_in), .m_we(m_we), .m_out(m_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_out = mem[m_addr[9:0]];
    always @(posedge clk) if (m_we) mem[m_addr[9:0]] <= m_in;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    initial begin
        bit exp_i, exp_d;
        bit prev_i, prev_d;
        logic [31:0] prev_word;
        n_tests = 0;
        n_fail  = 0;
        for (int k = 0; k < 1024; k++) mem[k] = {k[15:0], k[15:0]};
        mem[0] = 32'hA5A5_0000;
        rst = 1'b0; i_req = 0; i_addr = 0; d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'h1111_1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_d_ack", d_ack, 0);
        check("rst_i_ack", i_ack, 0);
        check("rst_m_we", m_we, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_i_rvalid", i_rvalid, 0);
        check("rst_d_err", d_err, 0);
        check("rst_i_err", i_err, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_i_rdata", i_rdata, 0);
        d_req = 0;
        rst = 1'b1;

        // store then load at byte 0x10 (word 4)
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        #1;
        check("st_d_ack", d_ack, 1);
        check("st_m_we", m_we, 1);
        check("st_m_addr", m_addr, 4);
        check("st_m_in", m_in, 32'hDEAD_BEEF);
        @(negedge clk);
        d_we = 0;
        #1;
        check("st_rvalid", d_rvalid, 1);
        check("st_old_rdata", d_rdata, 32'h0004_0004);
        check("ld_d_ack", d_ack, 1);
        check("ld_m_we", m_we, 0);
        @(negedge clk);
        d_req = 0;
        #1;
        check("ld_rvalid", d_rvalid, 1);
        check("ld_rdata", d_rdata, 32'hDEAD_BEEF);
        check("ld_err", d_err, 0);

        // both requesting: D x4, I, D x4, I
        @(negedge clk);
        i_req = 1; i_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h30;
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_i = (k == 4 || k == 9);
            check($sformatf("starve_i_ack%0d", k), i_ack, exp_i);
            check($sformatf("starve_d_ack%0d", k), d_ack, !exp_i);
            if (k == 5) begin
                check("starve_i_rvalid", i_rvalid, 1);
                check("starve_i_rdata", i_rdata, 32'h0008_0008);
                check("starve_d_rvalid", d_rvalid, 0);
            end
            @(negedge clk);
        end
        i_req = 0; d_req = 0;

        // misaligned store
        d_req = 1; d_we = 1; d_addr = 32'h13; d_wdata = 32'h1234_5678;
        #1;
        check("mis_d_ack", d_ack, 1);
        check("mis_m_we", m_we, 0);
        @(negedge clk);
        d_req = 0;
        #1;
        check("mis_rvalid", d_rvalid, 1);
        check("mis_err", d_err, 1);
        check("mis_rdata", d_rdata, 0);
        check("mis_mem4", mem[4], 32'hDEAD_BEEF);

        // fetch wraps modulo WORD
        @(negedge clk);
        i_req = 1; i_addr = 32'h1000;
        #1;
        check("wrap_i_ack", i_ack, 1);
        check("wrap_m_addr", m_addr, 0);
        check("wrap_m_we", m_we, 0);
        @(negedge clk);
        i_req = 0;
        #1;
        check("wrap_rvalid", i_rvalid, 1);
        check("wrap_rdata", i_rdata, 32'hA5A5_0000);
        check("wrap_err", i_err, 0);

        // reset in the cycle after an ack discards the response
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h8;
        #1;
        check("mr_d_ack", d_ack, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mr_rst_rvalid", d_rvalid, 0);
        check("mr_rst_rdata", d_rdata, 0);
        check("mr_rst_ack", d_ack, 0);
        check("mr_rst_m_we", m_we, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mr_rel_ack", d_ack, 1);
        check("mr_rel_rvalid", d_rvalid, 0);
        @(negedge clk);
        d_req = 0;
        #1;
        check("mr_rvalid", d_rvalid, 1);
        check("mr_rdata", d_rdata, 32'h0002_0002);

        // alternating single requests I, D, I, D
        prev_i = 0; prev_d = 0; prev_word = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_i = (k < 4) && (k % 2 == 0);
            exp_d = (k < 4) && (k % 2 == 1);
            i_req = exp_i; i_addr = 32'h40 + 32'(k * 4);
            d_req = exp_d; d_we = 0; d_addr = 32'h40 + 32'(k * 4);
            #1;
            check($sformatf("alt_i_ack%0d", k), i_ack, exp_i);
            check($sformatf("alt_d_ack%0d", k), d_ack, exp_d);
            check($sformatf("alt_both%0d", k), i_ack & d_ack, 0);
            check($sformatf("alt_i_rvalid%0d", k), i_rvalid, prev_i);
            check($sformatf("alt_d_rvalid%0d", k), d_rvalid, prev_d);
            if (prev_i) check($sformatf("alt_i_rdata%0d", k), i_rdata, prev_word);
            if (prev_d) check($sformatf("alt_d_rdata%0d", k), d_rdata, prev_word);
            prev_i = exp_i; prev_d = exp_d;
            prev_word = {16'(16 + k), 16'(16 + k)};
        end
        i_req = 0; d_req = 0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
